// File: rtl/somaserial_ctrl.sv
// somaserial_ctrl: bit-serial adder, one shared full-adder cell, LSB first, WIDTH cycles per add.
module somaserial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, psum;
   logic [CW-1:0] cnt;
   logic c, a_bit, b_bit, s, co, last;
   assign a_bit = a_sh[0];
   assign b_bit = b_sh[0];
   assign s = a_bit ^ b_bit ^ c;
   assign co = (a_bit & b_bit) | (c & (a_bit ^ b_bit));
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = start ? RUN : IDLE;
         RUN: state_nx = last ? DONE : RUN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         psum <= '0;
         cnt <= '0;
         c <= 1'b0;
         sum <= '0;
         carry_out <= 1'b0;
      end else if (state == IDLE && start) begin
         a_sh <= a;
         b_sh <= b;
         c <= carry_in;
         cnt <= '0;
      end else if (state == RUN) begin
         psum <= {s, psum[WIDTH-1:1]};
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         c <= co;
         cnt <= last ? cnt : cnt + CW'(1);
         if (last) begin
            sum <= {s, psum[WIDTH-1:1]};
            carry_out <= co;
         end
      end
   end
endmodule
